mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised N-master to one-slave memory arbiter. It sits between several requesters (CPU instruction port, CPU data port, future DMA or debug masters) and a single port of the memory controller. It arbitrates requests with round-robin fairness, forwards the winning request's valid/ready handshake, and tracks outstanding reads in an ID FIFO so that in-order read data is routed back to the correct master.

## Interface
- NUM_MASTERS, 2: number of request channels (2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.
- MAX_OUTSTANDING, 4: ID FIFO depth (power of two, ≥2).

- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- m_valid_in  input  NUM_MASTERS  per-master request valid.
- m_ready_out  output  NUM_MASTERS  per-master request accepted.
- m_addr_in  input  NUM_MASTERS*ADDR_W  flattened addresses; master i is at slice [i*ADDR_W +: ADDR_W].
- m_wdata_in  input  NUM_MASTERS*DATA_W  flattened write data.
- m_byte_en_in  input  NUM_MASTERS*DATA_W/8  flattened byte enables.
- m_write_en_in  input  NUM_MASTERS  1 = write, 0 = read.
- m_rdata_valid_out  output  NUM_MASTERS  one-hot read-data strobe.
- m_rdata_out  output  DATA_W  read data, broadcast to all masters.
- s_valid_out  output  1  request to slave.
- s_ready_in  input  1  slave accepts request.
- s_addr_out / s_wdata_out / s_byte_en_out / s_write_en_out / s_read_en_out  output  ADDR_W / DATA_W / DATA_W/8 / 1 / 1  muxed request fields.
- s_rdata_valid_in  input  1  slave read-data strobe (in order).
- s_rdata_in  input  DATA_W  slave read data.
- err_out  output  1  sticky: read data arrived with no outstanding read.

## Operation
- Grant is combinational from m_valid_in and the registered priority pointer `ptr`. The winner is the first valid master at or after `ptr`, searching modulo NUM_MASTERS.
- Blocking condition: the grant is blocked when the winner is a read and the ID FIFO is full.
- s_valid_out = a winner exists and the grant is not blocked. The s_* request fields are muxed from the winner. s_read_en_out = ~s_write_en_out.
- Ready path: m_ready_out[i] = grant[i] & s_ready_in & ~blocked.
- Transfer: a transfer completes when s_valid_out & s_ready_in. On a transfer:
  - `ptr` moves to winner+1, wrapping from NUM_MASTERS-1 to 0.
  - If the request is a read, the winner index is pushed into the ID FIFO.
- Writes do not enter the FIFO and produce no response.
- On s_rdata_valid_in:
  - The FIFO head is popped.
  - m_rdata_valid_out[head] = 1 in the same cycle.
  - m_rdata_out = s_rdata_in.
- Read data with the FIFO empty: the data is dropped, no strobe is issued, and err_out is set. err_out clears only on reset.
- Push and pop in the same cycle: occupancy is unchanged. A push is permitted when the FIFO is full only if a pop happens in the same cycle.
- The grant may switch while a master holds valid without ready. Masters hold their request fields until ready.

## Timing
- Request path is zero latency: valid, grant and ready are combinational, so a request can be accepted in the same cycle it is presented.
- Response path is zero-latency routing: s_rdata_valid_in → m_rdata_valid_out in the same cycle.
- State updates occur on the rising edge of clk: `ptr`, the FIFO pointers and count, and err_out.
- Reset (asynchronous assert, release synchronous to clk):
  - `ptr` = 0; FIFO empty; err_out = 0.
  - All outputs 0: m_ready_out, m_rdata_valid_out, and s_valid_out (no requests are valid during reset).
- Reset mid-operation: outstanding IDs are discarded. Later read data counts as empty-FIFO read data and sets err_out.
- Fairness: with all masters continuously requesting, each master is granted once every NUM_MASTERS transfers.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined:
  - `ptr` is held at 0, so the lowest-index valid master always wins.
  - The pointer register is removed.
- Not defined: round-robin as described above.

## Test plan
- Reset case: assert rst=0 with NUM_MASTERS=2 and all valids high → all outputs 0, err_out=0. Release → master 0 is granted first.
- Round-robin reads: masters 0 and 1 issue continuous reads with s_ready_in=1 → transfers alternate 0,1,0,1. Returned data 0xA,0xB,0xC,0xD strobes m_rdata_valid_out = 01,10,01,10.
- FIFO full: MAX_OUTSTANDING=4, 4 reads accepted, no data returned → s_valid_out=0 for a 5th read while a write from the other master is still accepted. One s_rdata_valid_in pop → the read is granted in the same cycle.
- Backpressure: s_ready_in=0 for 3 cycles with both valid → no m_ready_out, `ptr` unchanged, FIFO unchanged. When s_ready_in=1 the earlier winner is accepted.
- Spurious data: s_rdata_valid_in=1 with the FIFO empty → no m_rdata_valid_out, err_out=1 and it stays 1 until reset.
- MEM_ARB_FIXED_PRIO_EN build: masters 0 and 1 both continuously valid → master 0 wins every cycle and master 1 is never ready.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-master to one-slave memory request arbiter.
// Round-robin grant with a combinational valid/ready path. An in-order ID
// FIFO records which master issued each read so that returning read data is
// strobed back to that master.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (fixed priority, lowest index wins).
module mem_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_valid_in,
  output logic [NUM_MASTERS-1:0]          m_ready_out,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_in,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_in,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byte_en_in,
  input  logic [NUM_MASTERS-1:0]          m_write_en_in,
  output logic [NUM_MASTERS-1:0]          m_rdata_valid_out,
  output logic [DATA_W-1:0]               m_rdata_out,
  output logic                            s_valid_out,
  input  logic                            s_ready_in,
  output logic [ADDR_W-1:0]               s_addr_out,
  output logic [DATA_W-1:0]               s_wdata_out,
  output logic [DATA_W/8-1:0]             s_byte_en_out,
  output logic                            s_write_en_out,
  output logic                            s_read_en_out,
  input  logic                            s_rdata_valid_in,
  input  logic [DATA_W-1:0]               s_rdata_in,
  output logic                            err_out
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int FA_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = FA_W + 1;

  localparam logic [NUM_MASTERS-1:0] ONE_HOT_BASE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  // Priority pointer and arbitration signals
  logic [IDX_W-1:0]       ptr_s;
  logic                   win_found_s;
  logic [IDX_W-1:0]       win_idx_s;
  logic                   win_write_s;
  logic [NUM_MASTERS-1:0] grant_s;
  logic                   blocked_s;
  logic                   xfer_s;

  // ID FIFO state
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [FA_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FA_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [IDX_W-1:0] head_s;
  logic             err_q, err_d;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at master 0
  always_comb begin
    ptr_s = {IDX_W{1'b0}};
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Round-robin pointer advances past the winner of each transfer
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_s) begin
      if (win_idx_s == IDX_W'(NUM_MASTERS - 1)) begin
        ptr_d = {IDX_W{1'b0}};
      end else begin
        ptr_d = win_idx_s + IDX_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= {IDX_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_s = ptr_q;
  end
`endif

  // Winner search: first valid master at or after the pointer, modulo N
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand        = 0;
    cand_idx    = {IDX_W{1'b0}};
    win_found_s = 1'b0;
    win_idx_s   = {IDX_W{1'b0}};
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = int'(ptr_s) + k;
      if (cand >= NUM_MASTERS) begin
        cand = cand - NUM_MASTERS;
      end else begin
        cand = cand;
      end
      cand_idx = IDX_W'(cand);
      if (!win_found_s && m_valid_in[cand_idx]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_idx;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // FIFO status and head; a pop only happens when an ID is outstanding
  always_comb begin
    full_s  = (count_q == CNT_W'(MAX_OUTSTANDING));
    empty_s = (count_q == {CNT_W{1'b0}});
    head_s  = fifo_q[rd_ptr_q];
    pop_s   = rst & s_rdata_valid_in & ~empty_s;
  end

  // Request path: grant, blocking, slave mux and per-master ready
  always_comb begin
    win_write_s = m_write_en_in[win_idx_s];
    if (win_found_s) begin
      grant_s = ONE_HOT_BASE << win_idx_s;
    end else begin
      grant_s = {NUM_MASTERS{1'b0}};
    end
    // A same-cycle pop frees a slot, so a read may still enter a full FIFO
    blocked_s      = win_found_s & ~win_write_s & full_s & ~pop_s;
    s_valid_out    = rst & win_found_s & ~blocked_s;
    xfer_s         = s_valid_out & s_ready_in;
    push_s         = xfer_s & ~win_write_s;
    m_ready_out    = grant_s & {NUM_MASTERS{rst & s_ready_in & ~blocked_s}};
    s_addr_out     = m_addr_in[win_idx_s*ADDR_W +: ADDR_W];
    s_wdata_out    = m_wdata_in[win_idx_s*DATA_W +: DATA_W];
    s_byte_en_out  = m_byte_en_in[win_idx_s*BE_W +: BE_W];
    s_write_en_out = win_write_s;
    s_read_en_out  = ~win_write_s;
  end

  // Response path: route read data to the master at the FIFO head
  always_comb begin
    m_rdata_out = s_rdata_in;
    if (pop_s) begin
      m_rdata_valid_out = ONE_HOT_BASE << head_s;
    end else begin
      m_rdata_valid_out = {NUM_MASTERS{1'b0}};
    end
  end

  // FIFO pointer/count next state and sticky error accumulation
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + FA_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + FA_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q | (s_rdata_valid_in & empty_s);
  end

  // FIFO control and error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {FA_W{1'b0}};
      rd_ptr_q <= {FA_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // ID storage: write the winning master index on each read push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= {IDX_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= win_idx_s;
      end
    end
  end

  always_comb begin
    err_out = err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (2 masters, 4 outstanding reads).
// A small reference model (pointer + ID queue) predicts every cycle; read
// transfers push the expected master ID to a scoreboard queue that is popped
// when read data returns.
module tb_mem_arbiter;

  localparam int N    = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_valid_in;
  logic [N-1:0]    m_ready_out;
  logic [N*AW-1:0] m_addr_in;
  logic [N*DW-1:0] m_wdata_in;
  logic [N*DW/8-1:0] m_byte_en_in;
  logic [N-1:0]    m_write_en_in;
  logic [N-1:0]    m_rdata_valid_out;
  logic [DW-1:0]   m_rdata_out;
  logic            s_valid_out;
  logic            s_ready_in;
  logic [AW-1:0]   s_addr_out;
  logic [DW-1:0]   s_wdata_out;
  logic [DW/8-1:0] s_byte_en_out;
  logic            s_write_en_out;
  logic            s_read_en_out;
  logic            s_rdata_valid_in;
  logic [DW-1:0]   s_rdata_in;
  logic            err_out;

  mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .m_valid_in(m_valid_in), .m_ready_out(m_ready_out),
    .m_addr_in(m_addr_in), .m_wdata_in(m_wdata_in), .m_byte_en_in(m_byte_en_in),
    .m_write_en_in(m_write_en_in),
    .m_rdata_valid_out(m_rdata_valid_out), .m_rdata_out(m_rdata_out),
    .s_valid_out(s_valid_out), .s_ready_in(s_ready_in),
    .s_addr_out(s_addr_out), .s_wdata_out(s_wdata_out), .s_byte_en_out(s_byte_en_out),
    .s_write_en_out(s_write_en_out), .s_read_en_out(s_read_en_out),
    .s_rdata_valid_in(s_rdata_valid_in), .s_rdata_in(s_rdata_in),
    .err_out(err_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   ptr_m;
  int   ids[$];
  logic err_m;

  logic [AW-1:0]   addr_a [N];
  logic [DW-1:0]   wdata_a [N];
  logic [DW/8-1:0] be_a [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check model predictions, then advance model
  task automatic step(input logic [1:0] v, input logic [1:0] we, input logic srdy,
                      input logic rdv, input logic [31:0] rd);
    bit       found;
    int       win;
    bit       full_m, pop_m, blocked, exp_sv;
    logic [1:0] exp_rdy, exp_rv;
    @(negedge clk);
    m_valid_in = v; m_write_en_in = we; s_ready_in = srdy;
    s_rdata_valid_in = rdv; s_rdata_in = rd;
    #1;
    found = 1'b0; win = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr_m + k) % N;
      if (!found && v[c]) begin found = 1'b1; win = c; end
    end
    full_m  = (ids.size() == MAXO);
    pop_m   = rdv && (ids.size() > 0);
    blocked = found && !we[win] && full_m && !pop_m;
    exp_sv  = found && !blocked;
    exp_rdy = (exp_sv && srdy) ? (2'b01 << win) : 2'b00;
    exp_rv  = pop_m ? (2'b01 << ids[0]) : 2'b00;
    chk("s_valid", s_valid_out, exp_sv);
    chk("m_ready", m_ready_out, exp_rdy);
    chk("rdata_valid", m_rdata_valid_out, exp_rv);
    chk("err", err_out, err_m);
    if (exp_sv) begin
      chk("s_addr", s_addr_out, addr_a[win]);
      chk("s_wdata", s_wdata_out, wdata_a[win]);
      chk("s_be", s_byte_en_out, be_a[win]);
      chk("s_we", s_write_en_out, we[win]);
      chk("s_re", s_read_en_out, !we[win]);
    end
    if (pop_m) begin
      chk("rdata", m_rdata_out, rd);
      void'(ids.pop_front());
    end
    if (rdv && !pop_m) err_m = 1'b1;
    if (exp_sv && srdy) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr_m = (win + 1) % N;
`endif
      if (!we[win]) ids.push_back(win);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; m_valid_in = 2'b11; m_write_en_in = 2'b00; s_ready_in = 1'b1;
    s_rdata_valid_in = 1'b0;
    #1;
    chk("rst_s_valid", s_valid_out, 1'b0);
    chk("rst_m_ready", m_ready_out, 2'b00);
    chk("rst_rdata_valid", m_rdata_valid_out, 2'b00);
    chk("rst_err", err_out, 1'b0);
    ptr_m = 0; ids.delete(); err_m = 1'b0;
    @(negedge clk);
    m_valid_in = 2'b00;
    rst = 1'b1;
  endtask

  initial begin
    addr_a[0] = 32'h0000_1000; addr_a[1] = 32'h0000_2000;
    wdata_a[0] = 32'hD0D0_0000; wdata_a[1] = 32'hD1D1_0001;
    be_a[0] = 4'h3; be_a[1] = 4'hC;
    m_addr_in    = {addr_a[1], addr_a[0]};
    m_wdata_in   = {wdata_a[1], wdata_a[0]};
    m_byte_en_in = {be_a[1], be_a[0]};
    rst = 1'b0; m_valid_in = 2'b00; m_write_en_in = 2'b00; s_ready_in = 1'b0;
    s_rdata_valid_in = 1'b0; s_rdata_in = 32'h0;
    ptr_m = 0; err_m = 1'b0;

    do_reset();

`ifndef MEM_ARB_FIXED_PRIO_EN
    // Round-robin reads: 0,1,0,1 fills the ID FIFO
    step(2'b11, 2'b00, 1'b1, 1'b0, 32'h0); chk("rr0", m_ready_out, 2'b01);
    step(2'b11, 2'b00, 1'b1, 1'b0, 32'h0); chk("rr1", m_ready_out, 2'b10);
    step(2'b11, 2'b00, 1'b1, 1'b0, 32'h0); chk("rr2", m_ready_out, 2'b01);
    step(2'b11, 2'b00, 1'b1, 1'b0, 32'h0); chk("rr3", m_ready_out, 2'b10);
    // FIFO full: 5th read blocked, write still accepted
    step(2'b01, 2'b00, 1'b1, 1'b0, 32'h0); chk("full_blk", s_valid_out, 1'b0);
    step(2'b10, 2'b10, 1'b1, 1'b0, 32'h0); chk("full_wr", m_ready_out, 2'b10);
    // Pop frees a slot: blocked read is granted in the same cycle
    step(2'b01, 2'b00, 1'b1, 1'b1, 32'hA);
    chk("pop_grant", m_ready_out, 2'b01); chk("dA", m_rdata_valid_out, 2'b01);
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'hB); chk("dB", m_rdata_valid_out, 2'b10);
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'hC); chk("dC", m_rdata_valid_out, 2'b01);
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'hD); chk("dD", m_rdata_valid_out, 2'b10);
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'hE); chk("dE", m_rdata_valid_out, 2'b01);
    // Backpressure: winner (master 1) held, then accepted
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 2'b00, 1'b0, 1'b0, 32'h0);
      chk("bp_rdy", m_ready_out, 2'b00); chk("bp_addr", s_addr_out, 32'h0000_2000);
    end
    step(2'b11, 2'b00, 1'b1, 1'b0, 32'h0); chk("bp_acc", m_ready_out, 2'b10);
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'hF); chk("dF", m_rdata_valid_out, 2'b10);
    // Spurious data sets sticky error
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'h55); chk("spur_rv", m_rdata_valid_out, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 2'b00, 1'b1, 1'b0, 32'h0); chk("err_sticky", err_out, 1'b1);
    end
    // Reset mid-operation discards outstanding IDs
    step(2'b01, 2'b00, 1'b1, 1'b0, 32'h0); chk("mid_rd", m_ready_out, 2'b01);
    do_reset();
    step(2'b00, 2'b00, 1'b1, 1'b1, 32'h77); chk("post_rst_rv", m_rdata_valid_out, 2'b00);
    step(2'b00, 2'b00, 1'b1, 1'b0, 32'h0); chk("post_rst_err", err_out, 1'b1);
`else
    // Fixed priority: master 0 always wins, master 1 never ready
    step(2'b11, 2'b00, 1'b1, 1'b0, 32'h0); chk("fp0", m_ready_out, 2'b01);
    for (int i = 0; i < 6; i++) begin
      step(2'b11, 2'b00, 1'b1, 1'b1, 32'h100 + i);
      chk("fp_rdy", m_ready_out, 2'b01); chk("fp_rv", m_rdata_valid_out, 2'b01);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
